l2_prefetch_late_rolling_sampler: RTL
=====================================

Name: l2_prefetch_late_rolling_sampler

Overview:
Producer side of the L2 prefetch-late rolling perf record stream. Accumulates two event counts per cycle, a numerator (late prefetches) and a denominator (total prefetch hits), over fixed windows of WINDOW enabled cycles. At each window close it emits one record {yAxisPt, xAxisPt, stamp} through a small FIFO. The record goes over a valid/ready handshake to the record writer/DPI sink. The block sits in the CoupledL2 perf-monitor path, between the prefetcher event taps and the rolling-record writer.

Parameters:
WINDOW, 1000, enabled cycles per window; legal range 1..2^32-1.
INC_W, 4, width of the per-cycle increment inputs.
DEPTH, 4, record FIFO depth; power of two, at least 2.

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low reset
en  in  1  sampling enable; gates increments and window progress
y_inc  in  INC_W  late-prefetch events this cycle (numerator)
x_inc  in  INC_W  total prefetch events this cycle (denominator)
flush  in  1  force-close the current window this cycle
out_valid  out  1  record available
out_ready  in  1  sink accepts record
out_yAxisPt  out  64  window numerator
out_xAxisPt  out  64  window denominator
out_stamp  out  64  cycle stamp of window close
drop_cnt  out  16  records lost to a full FIFO; saturating

Behaviour:
- Reset (reset=0, asynchronous): cyc, win_cnt, acc_y, acc_x, FIFO pointers/count and drop_cnt all clear to 0. out_valid=0. out_* data=0. Reset asserted mid-window discards the partial window and all queued records.
- cyc: 64-bit free-running counter. Increments every cycle regardless of en and wraps at 2^64.
- Enabled cycle (en=1):
  - acc_y += zero-extended y_inc; acc_x += zero-extended x_inc.
  - Both accumulators saturate at 2^64-1.
  - win_cnt increments.
- Cycle with en=0: accumulators and win_cnt hold. y_inc and x_inc are ignored.
- Close condition:
  - en=1 and win_cnt==WINDOW-1, or
  - flush=1 with (win_cnt!=0 or acc_y!=0 or acc_x!=0).
  - flush on an empty window is a no-op.
  - flush together with a natural close produces one record only.
- On close:
  - Record = {acc_y + this cycle's y_inc, acc_x + this cycle's x_inc, stamp=cyc}. Current-cycle increments count only when en=1. The sum saturates.
  - Record is pushed next edge. acc_y, acc_x and win_cnt clear to 0 that same edge.
- flush with en=0 is allowed: the record contains the accumulated values only.
- FIFO:
  - out_valid = FIFO not empty. out_* = head entry.
  - Head is stable while out_valid=1 and out_ready=0.
  - Pop on out_valid && out_ready.
- Push when full:
  - Without a pop in the same cycle: record is dropped and drop_cnt increments, saturating at 0xFFFF.
  - With a pop in the same cycle: push is accepted, occupancy is unchanged, no drop.
- Latency: a closing cycle at edge N gives out_valid=1 after edge N when the FIFO was empty. Registered output, one cycle.
- WINDOW=1: every enabled cycle closes.
- No combinational path from out_ready to out_valid.

Test Plan:
1. WINDOW=4, en=1, y_inc=1, x_inc=2 for 4 cycles, out_ready=1, reset released at cyc=0 -> one record y=4, x=8, stamp=3. Accumulators are 0 afterwards.
2. WINDOW=4, en toggles 1,0,1,0,1,1 with y_inc=3, x_inc=5 -> record after the 4th enabled cycle: y=12, x=20. Stamp is the cyc of that cycle.
3. Flush on the 2nd enabled cycle of a WINDOW=8 run (y_inc=1) -> record y=2. Flush next on an empty window -> no record. Flush coinciding with the natural close -> exactly one record.
4. DEPTH=4, WINDOW=1, out_ready=0 for 6 enabled cycles -> 4 records queued, drop_cnt=2, head stable. Raise out_ready together with a push while full -> no drop, occupancy stays 4.
5. Preload acc_x near 2^64-1 via force, then x_inc=15 -> out_xAxisPt=0xFFFF_FFFF_FFFF_FFFF (saturated, no wrap).
6. Assert reset mid-window with 3 records queued -> out_valid drops to 0 asynchronously, drop_cnt=0. The first post-reset record holds only post-reset counts.

Source files
------------

// File: rtl/l2_prefetch_late_rolling_sampler.sv
// Rolling prefetch-late sampler: accumulates late/total prefetch counts over windows
// of WINDOW enabled cycles and queues one {y, x, stamp} record per window close.
`timescale 1ns/1ps
module l2_prefetch_late_rolling_sampler #(
    parameter int unsigned WINDOW = 1000,
    parameter int unsigned INC_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [INC_W-1:0] y_inc,
    input  logic [INC_W-1:0] x_inc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_yAxisPt,
    output logic [63:0]      out_xAxisPt,
    output logic [63:0]      out_stamp,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] WIN_LAST = 32'(WINDOW - 1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [INC_W-1:0] b);
        logic [64:0] s;
        s = {1'b0, a} + 65'(b);
        return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
    endfunction

    logic [63:0]      r_cyc;
    logic [31:0]      r_win_cnt;
    logic [63:0]      r_acc_y;
    logic [63:0]      r_acc_x;
    logic [15:0]      r_drop_cnt;

    logic [63:0]      r_mem_y [DEPTH];
    logic [63:0]      r_mem_x [DEPTH];
    logic [63:0]      r_mem_s [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [INC_W-1:0] w_y_inc;
    logic [INC_W-1:0] w_x_inc;
    logic [63:0]      w_y_sum;
    logic [63:0]      w_x_sum;
    logic             w_nonempty;
    logic             w_nat_close;
    logic             w_close;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Window accounting. Increments only count on enabled cycles; the closing
    // cycle's own increments are folded into the emitted record.
    always_comb begin
        w_y_inc     = en ? y_inc : '0;
        w_x_inc     = en ? x_inc : '0;
        w_y_sum     = sat_add(r_acc_y, w_y_inc);
        w_x_sum     = sat_add(r_acc_x, w_x_inc);
        w_nonempty  = (r_win_cnt != 32'd0) || (r_acc_y != 64'd0) || (r_acc_x != 64'd0);
        w_nat_close = en && (r_win_cnt == WIN_LAST);
        w_close     = w_nat_close || (flush && w_nonempty);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cyc     <= 64'd0;
            r_win_cnt <= 32'd0;
            r_acc_y   <= 64'd0;
            r_acc_x   <= 64'd0;
        end else begin
            r_cyc <= r_cyc + 64'd1;
            if (w_close) begin
                r_win_cnt <= 32'd0;
                r_acc_y   <= 64'd0;
                r_acc_x   <= 64'd0;
            end else if (en) begin
                r_win_cnt <= r_win_cnt + 32'd1;
                r_acc_y   <= w_y_sum;
                r_acc_x   <= w_x_sum;
            end
        end
    end

    // Record handshake: a record transfers on any edge where out_valid && out_ready.
    // out_valid and the head data come straight from registers, so out_ready never
    // reaches out_valid combinationally, and the head holds while stalled.
    always_comb begin
        w_full = (r_count == CNT_FULL);
        w_pop  = (r_count != '0) && out_ready;
        // A pop frees the slot the full FIFO would otherwise refuse.
        w_push = w_close && (!w_full || w_pop);
        w_drop = w_close && w_full && !w_pop;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_y <= '{default: '0};
            r_mem_x <= '{default: '0};
            r_mem_s <= '{default: '0};
        end else if (w_push) begin
            r_mem_y[r_wr_ptr] <= w_y_sum;
            r_mem_x[r_wr_ptr] <= w_x_sum;
            r_mem_s[r_wr_ptr] <= r_cyc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        out_valid   = (r_count != '0);
        out_yAxisPt = r_mem_y[r_rd_ptr];
        out_xAxisPt = r_mem_x[r_rd_ptr];
        out_stamp   = r_mem_s[r_rd_ptr];
        drop_cnt    = r_drop_cnt;
    end

endmodule
